// File: rtl/minisys_md_pkg.sv
// rtl/minisys_md_pkg.sv - shared op encodings, FSM state type and helpers for the HI/LO multiply/divide unit
package minisys_md_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 5;

    localparam logic [1:0] MD_MULT  = 2'b00;
    localparam logic [1:0] MD_MULTU = 2'b01;
    localparam logic [1:0] MD_DIV   = 2'b10;
    localparam logic [1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_FINISH = 2'd2
    } md_state_t;

    function automatic logic md_is_signed(input logic [1:0] op);
        return (op == MD_MULT) || (op == MD_DIV);
    endfunction

    function automatic logic md_is_div(input logic [1:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic [MD_WIDTH-1:0] md_cond_neg(input logic [MD_WIDTH-1:0] v, input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_md_unit_if.sv
// rtl/hilo_md_unit_if.sv - request/move/result bundle between the pipeline and the HI/LO unit
interface hilo_md_unit_if;
    import minisys_md_pkg::*;

    logic                start;
    logic [1:0]          op;
    logic [MD_WIDTH-1:0] operand_a;
    logic [MD_WIDTH-1:0] operand_b;
    logic                mthi;
    logic                mtlo;
    logic [MD_WIDTH-1:0] write_data;
    logic                busy;
    logic                done;
    logic [MD_WIDTH-1:0] hi;
    logic [MD_WIDTH-1:0] lo;

    modport master (
        output start, op, operand_a, operand_b, mthi, mtlo, write_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, operand_a, operand_b, mthi, mtlo, write_data,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/md_iter_core.sv
// rtl/md_iter_core.sv - radix-2 iterative datapath: shift-add multiply and restoring divide on magnitudes
module md_iter_core
    import minisys_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             div_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] res_hi_o,
    output logic [WIDTH-1:0] res_lo_o,
    output logic             last_o
);

    // acc holds the running product high half (with carry bit) or the partial remainder;
    // sh holds the multiplier shifting out / product low half, or dividend shifting into quotient.
    logic [WIDTH:0]        acc_q, acc_d;
    logic [WIDTH-1:0]      sh_q, sh_d;
    logic [WIDTH-1:0]      b_q, b_d;
    logic                  div_q, div_d;
    logic [MD_CNT_W-1:0]   cnt_q, cnt_d;

    logic [WIDTH:0]        mul_sum;
    logic [WIDTH:0]        rem_shift;
    logic [WIDTH:0]        rem_diff;

    always_comb begin
        mul_sum   = acc_q + (sh_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
        rem_shift = {acc_q[WIDTH-1:0], sh_q[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, b_q};

        acc_d = acc_q;
        sh_d  = sh_q;
        b_d   = b_q;
        div_d = div_q;
        cnt_d = cnt_q;

        if (load_i) begin
            acc_d = '0;
            sh_d  = a_i;
            b_d   = b_i;
            div_d = div_i;
            cnt_d = '0;
        end else if (step_i) begin
            cnt_d = cnt_q + {{(MD_CNT_W-1){1'b0}}, 1'b1};
            if (div_q) begin
                // Remainder stays below the divisor, so bit WIDTH of the difference is its sign.
                if (!rem_diff[WIDTH]) begin
                    acc_d = rem_diff;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b1};
                end else begin
                    acc_d = rem_shift;
                    sh_d  = {sh_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                acc_d = {1'b0, mul_sum[WIDTH:1]};
                sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_q <= '0;
            sh_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            sh_q  <= sh_d;
            b_q   <= b_d;
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign res_hi_o = acc_q[WIDTH-1:0];
    assign res_lo_o = sh_q;
    assign last_o   = (cnt_q == MD_CNT_W'(WIDTH - 1));

endmodule

// File: rtl/hilo_md_unit.sv
// rtl/hilo_md_unit.sv - HI/LO multiply/divide unit: control FSM, sign handling and HI/LO registers
module hilo_md_unit
    import minisys_md_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic          clock_i,
    input  logic          reset_i,
    hilo_md_unit_if.slave bus
);

    md_state_t          state_q;
    logic [1:0]         op_q;
    logic [WIDTH-1:0]   a_raw_q;
    logic               q_neg_q;
    logic               r_neg_q;
    logic               b_zero_q;
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               busy_q, done_q;

    logic               idle_ok;
    logic               accept;
    logic               sgn_op;
    logic               a_neg, b_neg;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               core_last;
    logic [WIDTH-1:0]   core_hi, core_lo;
    logic [2*WIDTH-1:0] prod_raw, prod_fix;
    logic [WIDTH-1:0]   fin_hi_d, fin_lo_d;

    // busy_q trails the return to IDLE by one cycle; requests wait until it drops.
    assign idle_ok = (state_q == ST_IDLE) && !busy_q;
    assign accept  = idle_ok && bus.start;

    assign sgn_op = md_is_signed(bus.op);
    assign a_neg  = sgn_op && bus.operand_a[WIDTH-1];
    assign b_neg  = sgn_op && bus.operand_b[WIDTH-1];
    assign a_mag  = md_cond_neg(bus.operand_a, a_neg);
    assign b_mag  = md_cond_neg(bus.operand_b, b_neg);

    md_iter_core #(.WIDTH(WIDTH)) u_core (
        .clk_i    (clock_i),
        .rst_i    (reset_i),
        .load_i   (accept),
        .step_i   (state_q == ST_RUN),
        .div_i    (md_is_div(bus.op)),
        .a_i      (a_mag),
        .b_i      (b_mag),
        .res_hi_o (core_hi),
        .res_lo_o (core_lo),
        .last_o   (core_last)
    );

    always_comb begin
        prod_raw = {core_hi, core_lo};
        prod_fix = q_neg_q ? -prod_raw : prod_raw;
        fin_hi_d = prod_fix[2*WIDTH-1:WIDTH];
        fin_lo_d = prod_fix[WIDTH-1:0];
        if (md_is_div(op_q)) begin
            if (b_zero_q) begin
                fin_hi_d = a_raw_q;
                fin_lo_d = '1;
            end else begin
                // 0x80000000 / -1 falls out naturally: magnitude quotient 2^31 negated wraps to itself.
                fin_hi_d = md_cond_neg(core_hi, r_neg_q);
                fin_lo_d = md_cond_neg(core_lo, q_neg_q);
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_MULT;
            a_raw_q  <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            busy_q <= (state_q != ST_IDLE);
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q  <= ST_RUN;
                        busy_q   <= 1'b1;
                        op_q     <= bus.op;
                        a_raw_q  <= bus.operand_a;
                        q_neg_q  <= a_neg ^ b_neg;
                        r_neg_q  <= a_neg;
                        b_zero_q <= (bus.operand_b == '0);
                    end else if (idle_ok) begin
                        if (bus.mthi) hi_q <= bus.write_data;
                        if (bus.mtlo) lo_q <= bus.write_data;
                    end
                end
                ST_RUN: begin
                    if (core_last) state_q <= ST_FINISH;
                end
                ST_FINISH: begin
                    hi_q    <= fin_hi_d;
                    lo_q    <= fin_lo_d;
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule
